mips_mc_controller: RTL and testbench

// - Multicycle MIPS control unit. Sequences each instruction through a Moore FSM.
// - Drives datapath mux selects and write strobes.
// - Produces the 3-bit ALU operation select consumed by the ALU; receives the ALU zero flag back.
// - Sits between the instruction register (op/funct) and the multicycle datapath.

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/mips_mc_controller_alu_decoder.sv | 49 ++++
 rtl/mips_mc_controller.sv | 159 +++++++++++++++
 tb/tb_mips_mc_controller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - state_t   : the 12 controller states
//   - aluop_t   : coarse ALU operation requested by the controller
//   - opcode / funct field values recognised by the controller
//   - 3-bit ALU select codes consumed by the ALU
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

endpackage

// File: rtl/mips_mc_controller_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational translation of the controller's coarse ALU request plus the
// instruction funct field into the 3-bit ALU select.
//   i_aluop        in  2  requested operation (ADD, SUB, or decode from funct)
//   i_funct        in  6  instr[5:0]
//   o_alucontrol   out 3  ALU select (AND/OR/ADD/SUB/SLT codes only)
//   o_funct_legal  out 1  funct is one of the supported R-type functions;
//                         depends on i_funct alone so it can gate writeback
//                         independently of the current ALU request
// -----------------------------------------------------------------------------
module alu_decoder
    import mips_pkg::*;
(
    input  aluop_t      i_aluop,
    input  logic [5:0]  i_funct,
    output logic [2:0]  o_alucontrol,
    output logic        o_funct_legal
);

    logic [2:0] w_funct_sel;

    always_comb begin
        w_funct_sel   = ALU_ADD;
        o_funct_legal = 1'b1;
        case (i_funct)
            FN_ADD:  w_funct_sel = ALU_ADD;
            FN_SUB:  w_funct_sel = ALU_SUB;
            FN_AND:  w_funct_sel = ALU_AND;
            FN_OR:   w_funct_sel = ALU_OR;
            FN_SLT:  w_funct_sel = ALU_SLT;
            default: begin
                w_funct_sel   = ALU_ADD;
                o_funct_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD:   o_alucontrol = ALU_ADD;
            ALUOP_SUB:   o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: o_alucontrol = w_funct_sel;
            default:     o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// -----------------------------------------------------------------------------
// mips_mc_controller
// Multicycle MIPS control unit: a Moore FSM that walks each instruction
// through fetch/decode/execute/writeback and drives the datapath selects and
// write strobes.
//   clk, reset   single clock, synchronous active-high reset
//   op, funct    opcode and funct fields from the instruction register
//   zero         ALU zero flag (combinational from the ALU)
//   alucontrol   ALU select
//   alusrca      0=PC, 1=regA
//   alusrcb      00=regB, 01=4, 10=signimm, 11=signimm<<2
//   pcsrc        00=ALU result, 01=ALUOut, 10=jump target
//   iord         memory address: 0=PC, 1=ALUOut
//   regdst       0=rt, 1=rd
//   memtoreg     0=ALUOut, 1=memory data
//   irwrite, memwrite, regwrite, pcen   write strobes
// While reset is high every strobe is 0 and all selects show FETCH values.
// -----------------------------------------------------------------------------
module mips_mc_controller
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic [2:0]  alucontrol,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic        iord,
    output logic        regdst,
    output logic        memtoreg,
    output logic        irwrite,
    output logic        memwrite,
    output logic        regwrite,
    output logic        pcen
);

    state_t r_state;
    state_t w_next;
    aluop_t w_aluop;
    logic   w_pcwrite;
    logic   w_branch;
    logic   w_regwrite;
    logic   w_rtype_wb;
    logic   w_funct_legal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Defaults are the FETCH select values with all strobes off; reset and
    // unreachable encodings simply fall through to them.
    always_comb begin
        w_next     = S_FETCH;
        w_aluop    = ALUOP_ADD;
        alusrca    = 1'b0;
        alusrcb    = 2'b01;
        pcsrc      = 2'b00;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        w_regwrite = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_rtype_wb = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    irwrite   = 1'b1;
                    w_pcwrite = 1'b1;
                    w_next    = S_DECODE;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    case (op)
                        OP_LW, OP_SW: w_next = S_MEMADR;
                        OP_RTYPE:     w_next = S_RTYPEEX;
                        OP_BEQ:       w_next = S_BEQEX;
                        OP_ADDI:      w_next = S_ADDIEX;
                        OP_J:         w_next = S_JEX;
                        default:      w_next = S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    w_next  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    iord   = 1'b1;
                    w_next = S_MEMWB;
                end
                S_MEMWB: begin
                    w_regwrite = 1'b1;
                    memtoreg   = 1'b1;
                end
                S_MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_RTYPEEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b00;
                    w_aluop = ALUOP_FUNCT;
                    w_next  = S_RTYPEWB;
                end
                S_RTYPEWB: begin
                    w_regwrite = 1'b1;
                    w_rtype_wb = 1'b1;
                    regdst     = 1'b1;
                end
                S_BEQEX: begin
                    alusrca  = 1'b1;
                    alusrcb  = 2'b00;
                    w_aluop  = ALUOP_SUB;
                    w_branch = 1'b1;
                    pcsrc    = 2'b01;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    w_next  = S_ADDIWB;
                end
                S_ADDIWB: begin
                    w_regwrite = 1'b1;
                end
                S_JEX: begin
                    w_pcwrite = 1'b1;
                    pcsrc     = 2'b10;
                end
                default: begin
                    w_next = S_FETCH;
                end
            endcase
        end
    end

    alu_decoder u_alu_decoder (
        .i_aluop       (w_aluop),
        .i_funct       (funct),
        .o_alucontrol  (alucontrol),
        .o_funct_legal (w_funct_legal)
    );

    // Unsupported funct turns the R-type writeback into a no-op. Applied
    // outside the FSM block so funct_legal never feeds back into the block
    // that produces the ALU request.
    assign regwrite = w_regwrite & ~(w_rtype_wb & ~w_funct_legal);
    assign pcen     = w_pcwrite | (w_branch & zero);

endmodule

// File: tb/tb_mips_mc_controller.sv
module tb_mips_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord, regdst, memtoreg, irwrite, memwrite, regwrite, pcen;

    int checks = 0;
    int errors = 0;

    mips_mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .iord(iord), .regdst(regdst), .memtoreg(memtoreg),
        .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite), .pcen(pcen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {alusrca, alusrcb, pcsrc, iord, regdst, memtoreg, irwrite, memwrite, regwrite, pcen, alucontrol}
    logic [14:0] obs;
    assign obs = {alusrca, alusrcb, pcsrc, iord, regdst, memtoreg,
                  irwrite, memwrite, regwrite, pcen, alucontrol};

    // Expected outputs per state: returns {mask, value}. Strobes (bits 6:3)
    // are always compared; selects only where the state defines them.
    // State 12 is the view while reset is held.
    function automatic logic [29:0] f_exp(input int s, input logic z, input logic [5:0] fn);
        logic [14:0] e;
        logic [14:0] m;
        logic [2:0]  fsel;
        logic        legal;
        e = '0;
        m = 15'h0078;
        legal = 1'b1;
        case (fn)
            6'b100000: fsel = 3'b010;
            6'b100010: fsel = 3'b110;
            6'b100100: fsel = 3'b000;
            6'b100101: fsel = 3'b001;
            6'b101010: fsel = 3'b111;
            default:   begin fsel = 3'b010; legal = 1'b0; end
        endcase
        case (s)
            0:  begin e = 15'b0_01_00_0_0_0_1_0_0_1_010; m = '1; end
            1:  begin e[13:12] = 2'b11; e[2:0] = 3'b010; m = m | 15'h3007; end
            2:  begin e[14] = 1'b1; e[13:12] = 2'b10; e[2:0] = 3'b010; m = m | 15'h7007; end
            3:  begin e[9] = 1'b1; m = m | 15'h0200; end
            4:  begin e[7] = 1'b1; e[4] = 1'b1; m = m | 15'h0180; end
            5:  begin e[9] = 1'b1; e[5] = 1'b1; m = m | 15'h0200; end
            6:  begin e[14] = 1'b1; e[13:12] = 2'b00; e[2:0] = fsel; m = m | 15'h7007; end
            7:  begin e[8] = 1'b1; e[4] = legal; m = m | 15'h0180; end
            8:  begin e[14] = 1'b1; e[11:10] = 2'b01; e[3] = z; e[2:0] = 3'b110; m = m | 15'h7C07; end
            9:  begin e[14] = 1'b1; e[13:12] = 2'b10; e[2:0] = 3'b010; m = m | 15'h7007; end
            10: begin e[4] = 1'b1; m = m | 15'h0180; end
            11: begin e[11:10] = 2'b10; e[3] = 1'b1; m = m | 15'h0C00; end
            default: begin e = 15'b0_01_00_0_0_0_0_0_0_0_010; m = '1; end
        endcase
        return {m, e};
    endfunction

    function automatic int f_next(input int s, input logic [5:0] o);
        case (s)
            0: return 1;
            1: case (o)
                   6'b100011, 6'b101011: return 2;
                   6'b000000: return 6;
                   6'b000100: return 8;
                   6'b001000: return 9;
                   6'b000010: return 11;
                   default:   return 0;
               endcase
            2: return (o == 6'b100011) ? 3 : 5;
            3: return 4;
            6: return 7;
            9: return 10;
            default: return 0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int seq[4] = '{0, 1, 2, 3};
        logic [29:0] x;
        reset = 1'b1; op = 6'b100011; funct = 6'b000000; zero = 1'b1;
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            x = f_exp(12, zero, funct);
            checks++;
            if ((obs & x[29:15]) !== x[14:0]) begin
                errors++;
                $display("FAIL reset_init%0d got=%b want=%b", k, obs, x[14:0]);
            end
            tick();
        end
        reset = 1'b0; #1;
        x = f_exp(0, zero, funct);
        checks++;
        if ((obs & x[29:15]) !== x[14:0]) begin
            errors++;
            $display("FAIL reset_release got=%b want=%b", obs, x[14:0]);
        end
        // advance a lw to MEMRD, then reset for three edges
        foreach (seq[k]) begin
            x = f_exp(seq[k], zero, funct);
            checks++;
            if ((obs & x[29:15]) !== x[14:0]) begin
                errors++;
                $display("FAIL reset_pre_lw%0d got=%b want=%b", k, obs, x[14:0]);
            end
            if (k < 3) tick();
        end
        reset = 1'b1; #1;
        for (int k = 0; k < 3; k++) begin
            x = f_exp(12, zero, funct);
            checks++;
            if ((obs & x[29:15]) !== x[14:0]) begin
                errors++;
                $display("FAIL reset_mid%0d got=%b want=%b", k, obs, x[14:0]);
            end
            tick();
        end
        reset = 1'b0; #1;
        x = f_exp(0, zero, funct);
        checks++;
        if ((obs & x[29:15]) !== x[14:0] || irwrite !== 1'b1) begin
            errors++;
            $display("FAIL reset_after got=%b want=%b", obs, x[14:0]);
        end
    endtask

    task automatic test_lw;
        int seq[6] = '{0, 1, 2, 3, 4, 0};
        logic [29:0] x;
        op = 6'b100011; funct = 6'b000000; zero = 1'b1; #1;
        foreach (seq[k]) begin
            x = f_exp(seq[k], zero, funct);
            checks++;
            if ((obs & x[29:15]) !== x[14:0]) begin
                errors++;
                $display("FAIL lw_cyc%0d got=%b want=%b", k, obs, x[14:0]);
            end
            if (k < 5) tick();
        end
    endtask

    task automatic test_sw;
        int seq[5] = '{0, 1, 2, 5, 0};
        logic [29:0] x;
        op = 6'b101011; funct = 6'b100000; zero = 1'b1; #1;
        foreach (seq[k]) begin
            x = f_exp(seq[k], zero, funct);
            checks++;
            if ((obs & x[29:15]) !== x[14:0]) begin
                errors++;
                $display("FAIL sw_cyc%0d got=%b want=%b", k, obs, x[14:0]);
            end
            if (k < 4) tick();
        end
    endtask

    task automatic test_rtype;
        logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
        logic [2:0] sel[6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
        logic       wr[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int seq[5] = '{0, 1, 6, 7, 0};
        logic [29:0] x;
        foreach (fns[i]) begin
            op = 6'b000000; funct = fns[i]; zero = 1'b1; #1;
            foreach (seq[k]) begin
                x = f_exp(seq[k], zero, funct);
                checks++;
                if ((obs & x[29:15]) !== x[14:0]) begin
                    errors++;
                    $display("FAIL rtype_f%b_cyc%0d got=%b want=%b", funct, k, obs, x[14:0]);
                end
                if (seq[k] == 6) begin
                    checks++;
                    if (alucontrol !== sel[i]) begin
                        errors++;
                        $display("FAIL rtype_alu_f%b got=%b want=%b", funct, alucontrol, sel[i]);
                    end
                end
                if (seq[k] == 7) begin
                    checks++;
                    if (regwrite !== wr[i]) begin
                        errors++;
                        $display("FAIL rtype_wr_f%b got=%b want=%b", funct, regwrite, wr[i]);
                    end
                end
                if (k < 4) tick();
            end
        end
    endtask

    task automatic test_beq;
        int seq[4] = '{0, 1, 8, 0};
        logic [29:0] x;
        for (int zi = 1; zi >= 0; zi--) begin
            op = 6'b000100; funct = 6'b000000; zero = 1'(zi); #1;
            foreach (seq[k]) begin
                x = f_exp(seq[k], zero, funct);
                checks++;
                if ((obs & x[29:15]) !== x[14:0]) begin
                    errors++;
                    $display("FAIL beq_z%0d_cyc%0d got=%b want=%b", zi, k, obs, x[14:0]);
                end
                if (k < 3) tick();
            end
        end
    endtask

    task automatic test_addi_j_illegal;
        logic [5:0] ops[3] = '{6'b001000, 6'b000010, 6'b111111};
        int seqs[3][5] = '{'{0, 1, 9, 10, 0}, '{0, 1, 11, 0, 0}, '{0, 1, 0, 0, 0}};
        int lens[3] = '{5, 4, 3};
        logic [29:0] x;
        foreach (ops[i]) begin
            op = ops[i]; funct = 6'b100010; zero = 1'b1; #1;
            for (int k = 0; k < lens[i]; k++) begin
                x = f_exp(seqs[i][k], zero, funct);
                checks++;
                if ((obs & x[29:15]) !== x[14:0]) begin
                    errors++;
                    $display("FAIL op%b_cyc%0d got=%b want=%b", op, k, obs, x[14:0]);
                end
                if (k < lens[i] - 1) tick();
            end
        end
    endtask

    task automatic test_random;
        logic [5:0] ops[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b010101};
        logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
        int s = 0;
        logic [29:0] x;
        for (int c = 0; c < 400; c++) begin
            if (s == 0) begin
                op = ops[$urandom_range(0, 6)];
                funct = fns[$urandom_range(0, 5)];
            end
            zero = 1'($urandom_range(0, 1));
            #1;
            x = f_exp(s, zero, funct);
            checks++;
            if ((obs & x[29:15]) !== x[14:0]) begin
                errors++;
                $display("FAIL rand_c%0d_s%0d got=%b want=%b", c, s, obs, x[14:0]);
            end
            checks++;
            if (memwrite && regwrite) begin
                errors++;
                $display("FAIL rand_mw_rw_c%0d got=11 want=not both", c);
            end
            checks++;
            if (pcen && !(s == 0 || s == 8 || s == 11)) begin
                errors++;
                $display("FAIL rand_pcen_c%0d_s%0d got=1 want=0", c, s);
            end
            tick();
            s = f_next(s, op);
        end
    endtask

    initial begin
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_addi_j_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
